sram_serial_loader: RTL and testbench

Host-side sequencer that drives the BNN top-level serial SRAM-access pins (SRAMSEL/SRAMA/SRAMMUX/SRAMCEN/SRAMWEN/SRAMDIN/SRAMDOUT). It accepts parallel read/write commands over a valid/ready interface and serialises them into bit-serial shift, commit, and capture sequences. It sits directly upstream of the accelerator top and is the only agent that preloads INST_SRAM (16-bit) and DATA_SRAM (32-bit) and reads results back while the BNN core is held off.

---
 rtl/sram_loader_pkg.sv | 20 ++
 rtl/sram_bit_shifter.sv | 49 ++++
 rtl/sram_serial_loader.sv | 203 ++++++++++++++++++++
 tb/tb_sram_serial_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_loader_pkg.sv
// Shared types and defaults for the serial SRAM loader.
package sram_loader_pkg;

  localparam int DATA_W_DEFAULT  = 32;
  localparam int INST_W_DEFAULT  = 16;
  localparam int INST_AW_DEFAULT = 11;
  localparam int CNT_W           = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSHIFT,
    S_WCOMMIT,
    S_RACCESS,
    S_RWAIT,
    S_RSHIFT,
    S_RESP,
    S_GAP
  } state_t;

endpackage

// File: rtl/sram_bit_shifter.sv
// Shift register shared by the write (serial out) and read (serial in) paths.
// The bit counter runs down from W-1; done is raised on the last bit.
module sram_bit_shifter
  import sram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int INST_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_wide,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              serial_in,
  output logic              shift_out,
  output logic [DATA_W-1:0] shifted,
  output logic              done
);

  logic [DATA_W-1:0] sr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              wide_reg;

  // Value the register takes on the next shift; also the final read word.
  assign shifted   = {sr_reg[DATA_W-2:0], serial_in};
  // Serial output taken from bit W-1 of the active word width.
  assign shift_out = wide_reg ? sr_reg[DATA_W-1] : sr_reg[INST_W-1];
  assign done      = (cnt_reg == '0);

  // Load a new word and bit count, or shift one bit and count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg   <= '0;
      cnt_reg  <= '0;
      wide_reg <= 1'b0;
    end else if (load) begin
      sr_reg   <= load_data;
      cnt_reg  <= load_wide ? CNT_W'(DATA_W - 1) : CNT_W'(INST_W - 1);
      wide_reg <= load_wide;
    end else if (shift) begin
      sr_reg <= shifted;
      if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_serial_loader.sv
// Host-side sequencer: turns parallel read/write commands into bit-serial
// shift / commit / capture sequences on the accelerator SRAM access pins.
module sram_serial_loader
  import sram_loader_pkg::*;
#(
  parameter int ADDRWIDTH = 13,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int INST_W    = INST_W_DEFAULT,
  parameter int INST_AW   = INST_AW_DEFAULT,
  parameter int READ_LAT  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENABLE,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic                 CMD_MUX,
  input  logic [ADDRWIDTH-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0]    CMD_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [DATA_W-1:0]    RSP_RDATA,
  output logic                 BUSY,
  output logic                 SRAMSEL,
  output logic [ADDRWIDTH-1:0] SRAMA,
  output logic                 SRAMMUX,
  output logic                 SRAMCEN,
  output logic                 SRAMWEN,
  output logic                 SRAMDIN,
  input  logic                 SRAMDOUT
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT > 0 ? READ_LAT - 1 : 0);

  state_t                state_reg, state_next;
  logic [ADDRWIDTH-1:0]  addr_reg, addr_next, inst_addr;
  logic                  mux_reg, mux_next;
  logic                  cen_reg, cen_next;
  logic                  wen_reg, wen_next;
  logic                  din_reg, din_next;
  logic                  sel_reg;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]     rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]            lat_reg, lat_next;
  logic                  sh_load, sh_wide, sh_shift, sh_out, sh_done;
  logic [DATA_W-1:0]     sh_load_data, sh_shifted;
  logic                  accept;

  // INST_SRAM addresses keep only the low INST_AW bits.
  genvar gi;
  generate
    for (gi = 0; gi < ADDRWIDTH; gi++) begin : g_inst_addr
      if (gi < INST_AW) begin : g_keep
        assign inst_addr[gi] = CMD_ADDR[gi];
      end else begin : g_zero
        assign inst_addr[gi] = 1'b0;
      end
    end
  endgenerate

  // Commands are taken only once SRAM ownership has been granted to the loader.
  assign CMD_READY = (state_reg == S_IDLE) && ENABLE && !rsp_valid_reg && sel_reg;
  assign accept    = CMD_READY && CMD_VALID;
  assign BUSY      = (state_reg != S_IDLE);

  assign SRAMSEL   = sel_reg;
  assign SRAMA     = addr_reg;
  assign SRAMMUX   = mux_reg;
  assign SRAMCEN   = cen_reg;
  assign SRAMWEN   = wen_reg;
  assign SRAMDIN   = din_reg;
  assign RSP_VALID = rsp_valid_reg;
  assign RSP_RDATA = rsp_rdata_reg;

  // Write data is preloaded one bit ahead so shift_out is always the next DIN bit.
  sram_bit_shifter #(
    .DATA_W (DATA_W),
    .INST_W (INST_W)
  ) u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .load      (sh_load),
    .load_wide (sh_wide),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .serial_in (SRAMDOUT),
    .shift_out (sh_out),
    .shifted   (sh_shifted),
    .done      (sh_done)
  );

  // Next-state and next-output decode; outputs reflect the state they belong to.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    mux_next       = mux_reg;
    cen_next       = 1'b1;
    wen_next       = 1'b1;
    din_next       = 1'b0;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    lat_next       = lat_reg;
    sh_load        = 1'b0;
    sh_wide        = mux_reg;
    sh_load_data   = '0;
    sh_shift       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          addr_next = CMD_MUX ? CMD_ADDR : inst_addr;
          mux_next  = CMD_MUX;
          if (CMD_WRITE) begin
            state_next   = S_WSHIFT;
            din_next     = CMD_MUX ? CMD_WDATA[DATA_W-1] : CMD_WDATA[INST_W-1];
            sh_load      = 1'b1;
            sh_wide      = CMD_MUX;
            sh_load_data = {CMD_WDATA[DATA_W-2:0], 1'b0};
          end else begin
            state_next = S_RACCESS;
            cen_next   = 1'b0;
          end
        end
      end
      S_WSHIFT: begin
        if (sh_done) begin
          state_next = S_WCOMMIT;
          cen_next   = 1'b0;
          wen_next   = 1'b0;
          din_next   = din_reg;
        end else begin
          sh_shift = 1'b1;
          din_next = sh_out;
        end
      end
      S_WCOMMIT: begin
        state_next = S_GAP;
      end
      S_RACCESS: begin
        // Clear the capture register so narrow reads come back zero-extended.
        sh_load    = 1'b1;
        sh_wide    = mux_reg;
        lat_next   = LAT_INIT;
        state_next = (READ_LAT == 0) ? S_RSHIFT : S_RWAIT;
      end
      S_RWAIT: begin
        if (lat_reg == 2'd0) begin
          state_next = S_RSHIFT;
        end else begin
          lat_next = lat_reg - 2'd1;
        end
      end
      S_RSHIFT: begin
        sh_shift = 1'b1;
        if (sh_done) begin
          state_next     = S_RESP;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = sh_shifted;
        end
      end
      S_RESP: begin
        if (RSP_READY) begin
          rsp_valid_next = 1'b0;
          state_next     = S_GAP;
        end
      end
      S_GAP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered SRAM-side / response outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      addr_reg      <= '0;
      mux_reg       <= 1'b0;
      cen_reg       <= 1'b1;
      wen_reg       <= 1'b1;
      din_reg       <= 1'b0;
      sel_reg       <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      lat_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      mux_reg       <= mux_next;
      cen_reg       <= cen_next;
      wen_reg       <= wen_next;
      din_reg       <= din_next;
      sel_reg       <= ENABLE || (state_reg != S_IDLE);
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      lat_reg       <= lat_next;
    end
  end

endmodule

// File: tb/tb_sram_serial_loader.sv
// Randomized self-checking bench: a pin-level SRAM model plus a per-cycle
// expectation queue derived from the command sequence rules.
module tb_sram_serial_loader;

  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int IAW = 11;
  localparam int LAT = 1;
  localparam logic [AW-1:0] IMASK = AW'((1 << IAW) - 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          ENABLE = 1'b0;
  logic          CMD_VALID = 1'b0;
  logic          CMD_WRITE = 1'b0;
  logic          CMD_MUX = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_WDATA = '0;
  logic          RSP_READY = 1'b0;
  logic          SRAMDOUT = 1'b0;
  logic          CMD_READY, RSP_VALID, BUSY, SRAMSEL, SRAMMUX, SRAMCEN, SRAMWEN, SRAMDIN;
  logic [DW-1:0] RSP_RDATA;
  logic [AW-1:0] SRAMA;

  sram_serial_loader #(
    .ADDRWIDTH (AW), .DATA_W (DW), .INST_W (IW), .INST_AW (IAW), .READ_LAT (LAT)
  ) dut (
    .CLK (CLK), .RST (RST), .ENABLE (ENABLE),
    .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY), .CMD_WRITE (CMD_WRITE),
    .CMD_MUX (CMD_MUX), .CMD_ADDR (CMD_ADDR), .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID), .RSP_READY (RSP_READY), .RSP_RDATA (RSP_RDATA),
    .BUSY (BUSY), .SRAMSEL (SRAMSEL), .SRAMA (SRAMA), .SRAMMUX (SRAMMUX),
    .SRAMCEN (SRAMCEN), .SRAMWEN (SRAMWEN), .SRAMDIN (SRAMDIN), .SRAMDOUT (SRAMDOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit in_reset = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- pin-level SRAM model ----------------
  logic [DW-1:0] data_mem [0:8191];
  logic [IW-1:0] inst_mem [0:8191];
  logic [DW-1:0] ref_data [0:8191];
  logic [IW-1:0] ref_inst [0:8191];
  logic [DW-1:0] din_hist = '0;
  bit            dout_q[$];

  always @(negedge CLK) begin
    logic [DW-1:0] word;
    int w;
    if (!in_reset) begin
      if (!SRAMCEN && !SRAMWEN) begin
        if (SRAMMUX) data_mem[SRAMA] = din_hist;
        else         inst_mem[SRAMA] = din_hist[IW-1:0];
      end
      if (!SRAMCEN && SRAMWEN) begin
        word = SRAMMUX ? data_mem[SRAMA] : {16'h0, inst_mem[SRAMA]};
        w = SRAMMUX ? DW : IW;
        for (int i = 0; i < LAT; i++) dout_q.push_back(1'b0);
        for (int i = w - 1; i >= 0; i--) dout_q.push_back(word[i]);
      end
      din_hist = {din_hist[DW-2:0], SRAMDIN};
    end
  end

  always @(posedge CLK) begin
    #1;
    SRAMDOUT = (dout_q.size() > 0) ? dout_q.pop_front() : 1'b0;
  end

  // ---------------- per-cycle pin expectations ----------------
  typedef struct {
    logic          cen;
    logic          wen;
    logic          din;
    logic          mux;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic cen, input logic wen, input logic din,
                          input logic mux, input logic [AW-1:0] addr);
    exp_t e;
    e.cen = cen; e.wen = wen; e.din = din; e.mux = mux; e.addr = addr;
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!in_reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("op_cen", SRAMCEN, e.cen);
        chk("op_wen", SRAMWEN, e.wen);
        chk("op_din", SRAMDIN, e.din);
        chk("op_mux", SRAMMUX, e.mux);
        chk("op_addr", SRAMA, e.addr);
        chk("op_sel", SRAMSEL, 1'b1);
        chk("op_busy", BUSY, 1'b1);
      end else begin
        chk("idle_cen", SRAMCEN, 1'b1);
        chk("idle_wen", SRAMWEN, 1'b1);
        chk("idle_din", SRAMDIN, 1'b0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [AW-1:0] eff_addr(input bit mux, input logic [AW-1:0] a);
    return mux ? a : (a & IMASK);
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, SRAMSEL, 1'b0);
    chk({tag, "_a"}, SRAMA, '0);
    chk({tag, "_mux"}, SRAMMUX, 1'b0);
    chk({tag, "_cen"}, SRAMCEN, 1'b1);
    chk({tag, "_wen"}, SRAMWEN, 1'b1);
    chk({tag, "_din"}, SRAMDIN, 1'b0);
    chk({tag, "_rspv"}, RSP_VALID, 1'b0);
    chk({tag, "_rdata"}, RSP_RDATA, '0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_ready"}, CMD_READY, 1'b0);
  endtask

  // Waits for CMD_READY, presents one command for the accept edge, and queues
  // the pin activity every write and the read front-end must produce.
  task automatic issue(input bit wr, input bit mux, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    int n;
    int w;
    logic [AW-1:0] ea;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CMD_READY && n < 200);
    if (!CMD_READY) chk("cmd_ready_timeout", 1'b0, 1'b1);
    CMD_WRITE = wr; CMD_MUX = mux; CMD_ADDR = addr; CMD_WDATA = wd;
    CMD_VALID = 1'b1;
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    CMD_WDATA = $urandom;
    ea = eff_addr(mux, addr);
    w = mux ? DW : IW;
    if (wr) begin
      for (int k = 0; k < w; k++) push_exp(1'b1, 1'b1, wd[w-1-k], mux, ea);
      push_exp(1'b0, 1'b0, wd[0], mux, ea);
      push_exp(1'b1, 1'b1, 1'b0, mux, ea);
    end else begin
      push_exp(1'b0, 1'b1, 1'b0, mux, ea);
      for (int k = 0; k < LAT + w; k++) push_exp(1'b1, 1'b1, 1'b0, mux, ea);
    end
  endtask

  task automatic do_write(input bit mux, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic [AW-1:0] ea;
    issue(1'b1, mux, addr, wd);
    ea = eff_addr(mux, addr);
    if (mux) ref_data[ea] = wd;
    else     ref_inst[ea] = wd[IW-1:0];
  endtask

  task automatic do_read(input bit mux, input logic [AW-1:0] addr, input int hold,
                         input bit drop_en, output logic [DW-1:0] got);
    logic [AW-1:0] ea;
    logic [DW-1:0] exp;
    int n;
    issue(1'b0, mux, addr, '0);
    ea = eff_addr(mux, addr);
    exp = mux ? ref_data[ea] : {16'h0, ref_inst[ea]};
    if (drop_en) begin
      repeat (LAT + 6) @(negedge CLK);
      ENABLE = 1'b0;
    end
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!RSP_VALID && n < 100);
    chk("rsp_valid_seen", RSP_VALID, 1'b1);
    got = RSP_RDATA;
    chk("rsp_rdata", RSP_RDATA, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk("rsp_hold_valid", RSP_VALID, 1'b1);
      chk("rsp_hold_data", RSP_RDATA, exp);
    end
    RSP_READY = 1'b1;
    @(posedge CLK);
    #1;
    RSP_READY = 1'b0;
    push_exp(1'b1, 1'b1, 1'b0, mux, ea);
    chk("rsp_valid_drop", RSP_VALID, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] got;
    logic [7:0]    din_byte;
    logic [DW-1:0] old_val;
    int            ready_n;

    for (int i = 0; i < 8192; i++) begin
      data_mem[i] = $urandom;
      ref_data[i] = data_mem[i];
      inst_mem[i] = IW'($urandom);
      ref_inst[i] = inst_mem[i];
    end
    data_mem[13'h0123] = 32'hDEADBEEF; ref_data[13'h0123] = 32'hDEADBEEF;
    inst_mem[13'h0042] = 16'h8001;     ref_inst[13'h0042] = 16'h8001;

    // Reset state, then ownership and readiness one edge after release.
    ENABLE = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset_vals("rst");
    RST = 1'b0;
    @(posedge CLK);
    #1;
    in_reset = 1'b0;
    @(negedge CLK);
    chk("t1_sel", SRAMSEL, 1'b1);
    chk("t1_ready", CMD_READY, 1'b1);
    chk("t1_cen", SRAMCEN, 1'b1);
    chk("t1_wen", SRAMWEN, 1'b1);
    chk("t1_busy", BUSY, 1'b0);

    // Wide write: first DIN byte and commit address are literal; ready after 34 edges.
    do_write(1'b1, 13'h1ABC, 32'hA5A5_0F0F);
    din_byte = '0;
    ready_n = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n - 1 < 8) din_byte = {din_byte[6:0], SRAMDIN};
      if (n - 1 == 32) begin
        chk("t2_commit_cen", SRAMCEN, 1'b0);
        chk("t2_commit_addr", SRAMA, 13'h1ABC);
      end
      @(posedge CLK);
      #1;
      if (CMD_READY) begin
        ready_n = n;
        break;
      end
    end
    chk("t2_din_msb_byte", din_byte, 8'hA5);
    chk("t2_ready_latency", ready_n, 34);

    // Narrow write: address folds to the INST range.
    do_write(1'b0, 13'h1FFF, 32'hFFFF_1234);
    chk("t3_srama", SRAMA, 13'h07FF);
    chk("t3_mux", SRAMMUX, 1'b0);

    // Literal reads pin the model.
    do_read(1'b1, 13'h0123, 5, 1'b0, got);
    chk("t4_literal", got, 32'hDEADBEEF);
    do_read(1'b0, 13'h0042, 0, 1'b0, got);
    chk("t5_literal", got, 32'h0000_8001);
    do_read(1'b0, 13'h07FF, 1, 1'b0, got);
    chk("t3_readback", got, 32'h0000_1234);

    // Reset during shift cycle 10 of a write: no commit, then normal operation.
    old_val = ref_data[13'h0055];
    issue(1'b1, 1'b1, 13'h0055, ~old_val);
    repeat (10) @(posedge CLK);
    #2;
    RST = 1'b1;
    in_reset = 1'b1;
    exp_q.delete();
    dout_q.delete();
    #1;
    check_reset_vals("t6_abort");
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    in_reset = 1'b0;
    chk("t6_no_commit", data_mem[13'h0055], old_val);
    do_read(1'b1, 13'h0055, 0, 1'b0, got);
    do_write(1'b1, 13'h0055, 32'h1357_9BDF);
    do_read(1'b1, 13'h0055, 2, 1'b0, got);
    chk("t6_after_abort", got, 32'h1357_9BDF);

    // Randomized mix of reads and writes over a small address pool.
    for (int i = 0; i < 40; i++) begin
      bit            wr;
      bit            mux;
      logic [AW-1:0] a;
      wr  = 1'($urandom_range(0, 1));
      mux = 1'($urandom_range(0, 1));
      if (mux) a = AW'(13'h0100 + $urandom_range(0, 7));
      else     a = AW'($urandom_range(0, 7) | ($urandom_range(0, 3) << IAW));
      if (wr) do_write(mux, a, $urandom);
      else    do_read(mux, a, $urandom_range(0, 3), 1'b0, got);
    end

    // ENABLE dropped mid-read: read completes, SRAMSEL falls one edge after GAP.
    do_read(1'b1, 13'h0101, 1, 1'b1, got);
    @(posedge CLK);
    #1;
    chk("t7_sel_idle_first", SRAMSEL, 1'b1);
    @(posedge CLK);
    #1;
    chk("t7_sel_released", SRAMSEL, 1'b0);
    chk("t7_ready_low", CMD_READY, 1'b0);
    chk("t7_busy_low", BUSY, 1'b0);
    repeat (3) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
